// File: rtl/mem_stage_pkg.sv
// mem_stage_pkg: shared state encoding, address base and MEM/WB field layout for the memory stage.
package mem_stage_pkg;
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_t;

    localparam logic [31:0] ADDR_BASE_DEF = 32'd1024;
    localparam int DEST_W = 4;
    localparam int DATA_W = 32;

    typedef struct packed {
        logic              wb_en;
        logic              mem_r_en;
        logic [DEST_W-1:0] dest;
        logic [DATA_W-1:0] alu_result;
        logic [DATA_W-1:0] mem_result;
    } mem_wb_t;
endpackage

// File: rtl/mem_stage_ctrl_if.sv
// mem_stage_ctrl_if: req/ack data-memory port between the memory stage (master) and data memory (slave).
interface mem_stage_ctrl_if #(parameter int ADDR_W = 16);
    logic              req;
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [31:0]       wdata;
    logic [31:0]       rdata;
    logic              ack;

    modport master (output req, we, addr, wdata, input rdata, ack);
    modport slave  (input req, we, addr, wdata, output rdata, ack);
endinterface

// File: rtl/mem_wb_reg.sv
// mem_wb_reg: MEM/WB pipeline register; loads when not held, and while held keeps its
// fields but clears wb_en so a stalled instruction is never written back twice.
module mem_wb_reg
    import mem_stage_pkg::*;
(
    input  logic    clk,
    input  logic    rst,
    input  logic    hold,
    input  mem_wb_t d,
    output mem_wb_t q
);
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) q <= '0;
        else if (hold) q.wb_en <= 1'b0;
        else q <= d;
    end
endmodule

// File: rtl/mem_stage_ctrl.sv
// mem_stage_ctrl: ARM pipeline memory stage; runs load/store as a req/ack transaction,
// freezes upstream while it is outstanding, and feeds the MEM/WB register.
module mem_stage_ctrl
    import mem_stage_pkg::*;
#(
    parameter logic [31:0] ADDR_BASE = ADDR_BASE_DEF,
    parameter int          ADDR_W    = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 valid_in,
    input  logic                 mem_r_en_in,
    input  logic                 mem_w_en_in,
    input  logic                 wb_en_in,
    input  logic [DEST_W-1:0]    dest_in,
    input  logic [DATA_W-1:0]    alu_out_in,
    input  logic [DATA_W-1:0]    val_rm_in,
    mem_stage_ctrl_if.master     mem,
    output logic                 freeze,
    output logic                 wb_en,
    output logic                 wb_mem_r_en,
    output logic [DEST_W-1:0]    wb_dest,
    output logic [DATA_W-1:0]    wb_alu_result,
    output logic [DATA_W-1:0]    wb_mem_result
);
    state_t            state, state_next;
    logic              start;
    logic              we_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q, rdata_q;
    mem_wb_t           wb_d, wb_q;

    // Gating start with rst keeps freeze low while reset is held, even with a live memory op upstream.
    always_comb begin
        start      = rst && state == IDLE && valid_in && (mem_r_en_in || mem_w_en_in);
        freeze     = start || state == ACCESS;
        state_next = start ? ACCESS : state == ACCESS ? (mem.ack ? DONE : ACCESS) : IDLE;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= IDLE;
            addr_q  <= '0;
            we_q    <= 1'b0;
            wdata_q <= '0;
            rdata_q <= '0;
        end else begin
            state <= state_next;
            if (start) begin
                addr_q  <= ADDR_W'((alu_out_in - ADDR_BASE) >> 2);
                we_q    <= mem_w_en_in && !mem_r_en_in;
                wdata_q <= val_rm_in;
            end
            if (state == ACCESS && mem.ack && !we_q) rdata_q <= mem.rdata;
        end
    end

    assign mem.req   = state == ACCESS;
    assign mem.we    = we_q;
    assign mem.addr  = addr_q;
    assign mem.wdata = wdata_q;

    // Captured data only reaches write-back in DONE of a read; everything else loads zero.
    always_comb begin
        wb_d            = '0;
        wb_d.wb_en      = valid_in && wb_en_in;
        wb_d.mem_r_en   = mem_r_en_in;
        wb_d.dest       = dest_in;
        wb_d.alu_result = alu_out_in;
        wb_d.mem_result = (state == DONE && !we_q) ? rdata_q : '0;
    end

    mem_wb_reg u_mem_wb_reg (
        .clk  (clk),
        .rst  (rst),
        .hold (freeze),
        .d    (wb_d),
        .q    (wb_q)
    );

    assign wb_en         = wb_q.wb_en;
    assign wb_mem_r_en   = wb_q.mem_r_en;
    assign wb_dest       = wb_q.dest;
    assign wb_alu_result = wb_q.alu_result;
    assign wb_mem_result = wb_q.mem_result;
endmodule
